// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit path and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

  typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_ODD = 2'd1, PAR_EVEN = 2'd2} uart_parity_e;

  localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rd_data = mem[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: TX FIFO, runtime baud divisor, optional parity, 1/2 stop bits, CTS gating.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 20
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_BITS-1:0]              s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DIV_W-1:0]                  baud_rate,
  input  logic [1:0]                        parity_mode,
  input  logic                              stop2,
  input  logic                              CTS,
  output logic                              TX,
  output logic                              tx_busy,
  output logic                              tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  uart_tx_state_e        state_q;
  logic [DIV_W-1:0]      baud_cnt_q, div_q, div_in;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0]  shreg_q, fifo_rd_data;
  logic                  par_bit_q, par_en_q, stop2_q, stop_second_q;
  logic                  tx_q, tx_done_q;
  logic                  fifo_full, fifo_empty, pop, last_stop, frame_end, div_one;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (s_valid),
    .wr_data (s_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    div_in    = (baud_rate == '0) ? DIV_W'(1) : baud_rate;
    div_one   = (div_q == DIV_W'(1));
    last_stop = stop_second_q || !stop2_q;
    frame_end = (state_q == STOP) && (baud_cnt_q == '0) && last_stop;
    // A new frame starts from IDLE or directly out of the last stop cycle.
    pop       = !fifo_empty && CTS && ((state_q == IDLE) || frame_end);
    s_ready   = !fifo_full;
    TX        = tx_q;
    tx_done   = tx_done_q;
    tx_busy   = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tx_q          <= UART_IDLE_LVL;
      tx_done_q     <= 1'b0;
      baud_cnt_q    <= '0;
      div_q         <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      par_bit_q     <= 1'b0;
      par_en_q      <= 1'b0;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (pop) begin
        shreg_q       <= fifo_rd_data;
        par_bit_q     <= (parity_mode == PAR_EVEN) ? ^fifo_rd_data : ~^fifo_rd_data;
        par_en_q      <= (parity_mode == PAR_ODD) || (parity_mode == PAR_EVEN);
        stop2_q       <= stop2;
        div_q         <= div_in;
        baud_cnt_q    <= div_in - DIV_W'(1);
        bit_cnt_q     <= '0;
        stop_second_q <= 1'b0;
        tx_q          <= ~UART_IDLE_LVL;
        state_q       <= START;
      end else if (state_q != IDLE) begin
        if (baud_cnt_q != '0) begin
          baud_cnt_q <= baud_cnt_q - DIV_W'(1);
          // Registered pulse: raise it one cycle ahead so it covers the final stop cycle.
          if (state_q == STOP && baud_cnt_q == DIV_W'(1) && last_stop) tx_done_q <= 1'b1;
        end else begin
          baud_cnt_q <= div_q - DIV_W'(1);
          case (state_q)
            START: begin
              tx_q      <= shreg_q[0];
              bit_cnt_q <= '0;
              state_q   <= DATA;
            end
            DATA: begin
              if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                if (par_en_q) begin
                  tx_q    <= par_bit_q;
                  state_q <= PARITY;
                end else begin
                  tx_q          <= UART_IDLE_LVL;
                  stop_second_q <= 1'b0;
                  tx_done_q     <= div_one && !stop2_q;
                  state_q       <= STOP;
                end
              end else begin
                shreg_q   <= shreg_q >> 1;
                tx_q      <= shreg_q[1];
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              end
            end
            PARITY: begin
              tx_q          <= UART_IDLE_LVL;
              stop_second_q <= 1'b0;
              tx_done_q     <= div_one && !stop2_q;
              state_q       <= STOP;
            end
            STOP: begin
              if (!last_stop) begin
                stop_second_q <= 1'b1;
                tx_done_q     <= div_one;
              end else begin
                state_q <= IDLE;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
